// File: rtl/mascota_pkg.sv
// mascota_pkg: state encoding, level limit and counter sizing shared by the pet control blocks
package mascota_pkg;
  typedef enum logic [1:0] {
    REPOSO   = 2'd0,
    ACCION_C = 2'd1,
    ACCION_M = 2'd2,
    ESPERA   = 2'd3
  } estado_t;
  localparam logic [1:0] NIVEL_MAX_DEF = 2'd3;
  function automatic int ancho_contador(input int a, input int b);
    int m;
    m = a > b ? a : b;
    return m > 1 ? $clog2(m) : 1;
  endfunction
endpackage

// File: rtl/arbitro_acciones_if.sv
// arbitro_acciones_if: request/level inputs (master drives) and action/increment/status outputs (slave drives) of the action arbiter
interface arbitro_acciones_if;
  logic       Solicitud_Comida;
  logic       Solicitud_Medicina;
  logic [1:0] Nivel_Comida;
  logic [1:0] Nivel_Medicina;
  logic       Activo_Comida;
  logic       Activo_Medicina;
  logic       Incrementa_Comida;
  logic       Incrementa_Medicina;
  logic       Ocupado;
  logic       Rechazo;
  modport master (
    output Solicitud_Comida, Solicitud_Medicina, Nivel_Comida, Nivel_Medicina,
    input  Activo_Comida, Activo_Medicina, Incrementa_Comida, Incrementa_Medicina, Ocupado, Rechazo
  );
  modport slave (
    input  Solicitud_Comida, Solicitud_Medicina, Nivel_Comida, Nivel_Medicina,
    output Activo_Comida, Activo_Medicina, Incrementa_Comida, Incrementa_Medicina, Ocupado, Rechazo
  );
endinterface

// File: rtl/contador_ventana.sv
// contador_ventana: down-counter (clk, async active-low reset, carga loads valor, fin high at zero; holds at zero)
module contador_ventana #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         carga,
  input  logic [W-1:0] valor,
  output logic         fin
);
  logic [W-1:0] cuenta;
  always_ff @(posedge clk or negedge reset)
    if (!reset) cuenta <= '0;
    else if (carga) cuenta <= valor;
    else if (!fin) cuenta <= cuenta - W'(1);
  assign fin = cuenta == '0;
endmodule

// File: rtl/arbitro_acciones.sv
// arbitro_acciones: round-robin food/medicine action arbiter with fixed action window and cooldown (clk, async active-low reset, bus = slave side of arbitro_acciones_if)
module arbitro_acciones
  import mascota_pkg::*;
#(
  parameter int         CICLOS_ACCION = 50_000_000,
  parameter int         CICLOS_ESPERA = 25_000_000,
  parameter logic [1:0] NIVEL_MAX     = NIVEL_MAX_DEF
) (
  input logic               clk,
  input logic               reset,
  arbitro_acciones_if.slave bus
);
  localparam int W = ancho_contador(CICLOS_ACCION, CICLOS_ESPERA);
  estado_t estado, estado_d;
  logic pend_c, pend_m, ptr_m;
  logic sol_c, sol_m, cand_c, cand_m, elige_c, elige_m, lleno, concede, rechaza, carga, fin;
  logic [W-1:0] valor;
  always_comb begin
    sol_c    = bus.Solicitud_Comida && estado != ACCION_C;
    sol_m    = bus.Solicitud_Medicina && estado != ACCION_M;
    cand_c   = pend_c || sol_c;
    cand_m   = pend_m || sol_m;
    elige_c  = cand_c && (!cand_m || !ptr_m);
    elige_m  = cand_m && !elige_c;
    lleno    = elige_c ? bus.Nivel_Comida >= NIVEL_MAX : bus.Nivel_Medicina >= NIVEL_MAX;
    concede  = estado == REPOSO && (elige_c || elige_m) && !lleno;
    rechaza  = estado == REPOSO && (elige_c || elige_m) && lleno;
    carga    = concede || ((estado == ACCION_C || estado == ACCION_M) && fin);
    valor    = estado == REPOSO ? W'(CICLOS_ACCION - 1) : W'(CICLOS_ESPERA - 1);
    estado_d = estado == REPOSO ? (concede ? (elige_c ? ACCION_C : ACCION_M) : REPOSO)
             : !fin ? estado : estado == ESPERA ? REPOSO : ESPERA;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      estado                  <= REPOSO;
      pend_c                  <= 1'b0;
      pend_m                  <= 1'b0;
      ptr_m                   <= 1'b0;
      bus.Activo_Comida       <= 1'b0;
      bus.Activo_Medicina     <= 1'b0;
      bus.Incrementa_Comida   <= 1'b0;
      bus.Incrementa_Medicina <= 1'b0;
      bus.Ocupado             <= 1'b0;
      bus.Rechazo             <= 1'b0;
    end else begin
      estado                  <= estado_d;
      pend_c                  <= cand_c && !(estado == REPOSO && elige_c);
      pend_m                  <= cand_m && !(estado == REPOSO && elige_m);
      if (concede) ptr_m      <= elige_c;
      bus.Activo_Comida       <= estado_d == ACCION_C;
      bus.Activo_Medicina     <= estado_d == ACCION_M;
      bus.Incrementa_Comida   <= estado == ACCION_C && fin;
      bus.Incrementa_Medicina <= estado == ACCION_M && fin;
      bus.Ocupado             <= estado_d != REPOSO;
      bus.Rechazo             <= rechaza;
    end
  contador_ventana #(.W(W)) u_contador (
    .clk   (clk),
    .reset (reset),
    .carga (carga),
    .valor (valor),
    .fin   (fin)
  );
endmodule

// File: tb/tb_arbitro_acciones.sv
// tb_arbitro_acciones: directed scoreboard bench for arbitro_acciones with a 4-cycle window and 2-cycle cooldown
module tb_arbitro_acciones;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [5:0] exp_q[$];
  string tag_q[$];
  arbitro_acciones_if bus();
  arbitro_acciones #(.CICLOS_ACCION(4), .CICLOS_ESPERA(2), .NIVEL_MAX(2'd3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );
  always #5 clk = ~clk;
  function automatic logic [5:0] obs();
    return {bus.Activo_Comida, bus.Activo_Medicina, bus.Incrementa_Comida,
            bus.Incrementa_Medicina, bus.Ocupado, bus.Rechazo};
  endfunction
  task automatic check(input string t, input logic [5:0] o, input logic [5:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", t, o, e);
    end
  endtask
  task automatic push(input string t, input logic [5:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(v);
      tag_q.push_back(t);
    end
  endtask
  task automatic push_action(input string t, input bit com);
    push({t, "_act"}, com ? 6'b100010 : 6'b010010, 4);
    push({t, "_inc"}, com ? 6'b001010 : 6'b000110, 1);
    push({t, "_esp"}, 6'b000010, 1);
  endtask
  task automatic step();
    logic [5:0] o;
    @(posedge clk);
    #1;
    bus.Solicitud_Comida   = 1'b0;
    bus.Solicitud_Medicina = 1'b0;
    o = obs();
    check(tag_q.pop_front(), o, exp_q.pop_front());
    check("exclusion", {4'b0, o[5] & o[4], o[3] & o[2]}, 6'b0);
  endtask
  task automatic drain();
    while (exp_q.size() > 0) step();
  endtask
  task automatic pulse_reset();
    #2 reset = 1'b0;
    #2 reset = 1'b1;
  endtask
  initial begin
    bus.Solicitud_Comida   = 1'b0;
    bus.Solicitud_Medicina = 1'b0;
    bus.Nivel_Comida       = 2'd0;
    bus.Nivel_Medicina     = 2'd0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", obs(), 6'b0);
    reset = 1'b1;
    push("s1_pre", 6'b0, 3);
    drain();
    bus.Nivel_Comida = 2'd1;
    bus.Solicitud_Comida = 1'b1;
    push_action("s1", 1'b1);
    push("s1_idle", 6'b0, 2);
    drain();
    pulse_reset();
    push("s2_pre", 6'b0, 1);
    drain();
    bus.Solicitud_Comida = 1'b1;
    bus.Solicitud_Medicina = 1'b1;
    push_action("s2_c", 1'b1);
    push("s2_gap", 6'b0, 1);
    push_action("s2_m", 1'b0);
    push("s2_idle", 6'b0, 2);
    drain();
    bus.Solicitud_Comida = 1'b1;
    push_action("s2b_c", 1'b1);
    push("s2b_idle", 6'b0, 2);
    drain();
    bus.Solicitud_Comida = 1'b1;
    bus.Solicitud_Medicina = 1'b1;
    push_action("s2c_m", 1'b0);
    push("s2c_gap", 6'b0, 1);
    push_action("s2c_c", 1'b1);
    push("s2c_idle", 6'b0, 2);
    drain();
    bus.Nivel_Medicina = 2'd3;
    bus.Solicitud_Medicina = 1'b1;
    push("s3_rech", 6'b000001, 1);
    push("s3_idle", 6'b0, 4);
    drain();
    bus.Nivel_Medicina = 2'd2;
    bus.Solicitud_Medicina = 1'b1;
    push_action("s3_lim", 1'b0);
    push("s3_lim_idle", 6'b0, 2);
    drain();
    bus.Nivel_Medicina = 2'd0;
    bus.Solicitud_Comida = 1'b1;
    push_action("s4_c", 1'b1);
    push("s4_gap", 6'b0, 1);
    push_action("s4_m", 1'b0);
    push("s4_idle", 6'b0, 3);
    step();
    bus.Solicitud_Comida = 1'b1;
    step();
    bus.Solicitud_Comida = 1'b1;
    bus.Solicitud_Medicina = 1'b1;
    step();
    bus.Solicitud_Comida = 1'b1;
    drain();
    bus.Solicitud_Comida = 1'b1;
    push("s5_act", 6'b100010, 2);
    drain();
    #2 reset = 1'b0;
    #1 check("s5_reset_now", obs(), 6'b0);
    #2 reset = 1'b1;
    push("s5_after", 6'b0, 10);
    drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/arbitro_acciones.md
# arbitro_acciones

Serialises the pet's care actions: arbitrates between the feed and medicine requests coming from the hold-detector (`Modos`) block, grants one at a time, and holds an action window of fixed length, followed by a cooldown. While the window is open, the block drives the `Activo_*` signals toward the main state machine. At the end of each window it emits a one-cycle level-increment pulse. Requests for a resource already at full level are rejected, not granted.

## Interface
- `CICLOS_ACCION`, default 50_000_000: length of the action window in clk cycles (1 s at 50 MHz), minimum 1.
- `CICLOS_ESPERA`, default 25_000_000: length of the cooldown after each action, minimum 1.
- `NIVEL_MAX`, default 2'd3: level at or above which a request is rejected.

- `clk`  in  1  system clock; only clock.
- `reset`  in  1  asynchronous, active-low reset.
- `Solicitud_Comida`  in  1  single-cycle request pulse (food, after the 5 s hold).
- `Solicitud_Medicina`  in  1  single-cycle request pulse (medicine).
- `Nivel_Comida`  in  2  current food level.
- `Nivel_Medicina`  in  2  current medicine level.
- `Activo_Comida`  out  1  high for the whole food action window.
- `Activo_Medicina`  out  1  high for the whole medicine action window.
- `Incrementa_Comida`  out  1  one-cycle pulse: raise the food level by 1.
- `Incrementa_Medicina`  out  1  one-cycle pulse: raise the medicine level by 1.
- `Ocupado`  out  1  high in any state other than REPOSO.
- `Rechazo`  out  1  one-cycle pulse when a granted request is dropped because its level is at `NIVEL_MAX` or above.

## Operation
- **Pending flags:** one per kind, `pend_c` and `pend_m`.
  - A request pulse sets its flag.
  - A request of a kind already pending, or currently in its action window, is ignored silently.
  - A request of the other kind is latched in any state.
- **States:** REPOSO, ACCION_C, ACCION_M, ESPERA.
- **REPOSO.** The candidate set is the pending flags OR'd with this cycle's request pulses.
  - If both are candidates, pick the kind not granted last. The round-robin pointer starts at Comida after reset.
  - If the chosen kind's level is at or above `NIVEL_MAX`: clear its flag, pulse `Rechazo`, stay in REPOSO. The other kind is evaluated the next cycle.
  - Otherwise: clear its flag, load the counter with `CICLOS_ACCION`-1, go to ACCION_C or ACCION_M, and update the pointer.
- **ACCION_x.** Decrement the counter each cycle.
  - At 0: load `CICLOS_ESPERA`-1, go to ESPERA, and pulse `Incrementa_x` on that transition.
- **ESPERA.** Decrement the counter each cycle; at 0 go to REPOSO.
- **Counter width:** $clog2 of max(`CICLOS_ACCION`, `CICLOS_ESPERA`). It never wraps: loads only happen on transitions.
- **Rejection timing:** the level is sampled only at grant time. Level changes during a window have no effect.

## Timing
- All outputs are registered. Reset value of every output is 0; state = REPOSO, flags = 0, pointer = Comida.
- **Grant latency:** a request pulse in cycle t while in REPOSO with no other candidate gives `Activo_x` = 1 and `Ocupado` = 1 from cycle t+1.
- **Window length:** `Activo_x` stays high exactly `CICLOS_ACCION` cycles.
- **Increment pulse:** `Incrementa_x` is high only in the first ESPERA cycle, i.e. the cycle after `Activo_x` falls.
- **Back-to-back actions:** the next grant happens at the earliest in the cycle after ESPERA ends. Gap between windows = `CICLOS_ESPERA` + 1 cycles.
- **Rejection:** `Rechazo` is high in cycle t+1 for a request evaluated in cycle t.
- **Mutual exclusion:** `Activo_Comida` and `Activo_Medicina` are never high together. The two `Incrementa_*` pulses are never high together.
- **Reset mid-window:** all outputs drop immediately (asynchronous). No `Incrementa` pulse is emitted for the aborted action.

## Structure
- **Shared package `mascota_pkg`:** state encoding (REPOSO = 2'd0, ACCION_C = 2'd1, ACCION_M = 2'd2, ESPERA = 2'd3) and the `NIVEL_MAX` default. `Modos` and `Maquina_Estados_1` reuse the same package.
- **Sub-module `contador_ventana`:** parameterised down-counter with `carga`, `valor`, and `fin` (asserted at 0). Instantiated once and shared by the action and cooldown phases.

## Test plan
All scenarios use `CICLOS_ACCION` = 4, `CICLOS_ESPERA` = 2.
- Single food request at cycle 10, `Nivel_Comida` = 1 -> `Activo_Comida` high in cycles 11–14, `Incrementa_Comida` high in cycle 15, `Ocupado` low from cycle 17.
- Both requests in the same cycle, right after reset -> food granted first; medicine `Activo` starts 3 cycles after food `Activo` falls. A second simultaneous pair is served medicine first.
- `Nivel_Medicina` = 3 with a medicine request -> `Rechazo` pulse, no `Activo_Medicina`, no `Incrementa_Medicina`, `Ocupado` stays 0.
- Repeated food requests during a food window plus one medicine request -> exactly one extra action, medicine only.
- Reset asserted in the 2nd cycle of a window -> all outputs 0 immediately; after release, no increment pulse and no pending action remains.
